// File: rtl/lenet_acc_pkg.sv
// Shared types and constants for the LeNet product accumulator and requantiser.
// Window FSM states, product/activation widths and a width helper.
package lenet_acc_pkg;

    localparam int PROD_W = 16;
    localparam int Q_W    = 8;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_e;

    // Bits needed to count 0..n-1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lenet_requant_u8.sv
// Shift-and-saturate requantisation of an unsigned accumulator to an 8-bit activation.
// Purely combinational so later layers can reuse it on any accumulator width.
module lenet_requant_u8
    import lenet_acc_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 8
) (
    input  logic [ACC_W-1:0] acc,
    output logic [Q_W-1:0]   q
);

    logic [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >> SHIFT;
        if (shifted > ACC_W'(2**Q_W - 1)) begin
            q = '1;
        end else begin
            q = shifted[Q_W-1:0];
        end
    end

endmodule

// File: rtl/lenet_xfyw_mac_acc.sv
// Accumulates N_TERMS unsigned products into a saturating sum and holds the
// raw sum plus its 8-bit requantised activation until the consumer takes it.
module lenet_xfyw_mac_acc
    import lenet_acc_pkg::*;
#(
    parameter  int N_TERMS = 25,
    parameter  int ACC_W   = 24,
    parameter  int SHIFT   = 8,
    localparam int CNT_W   = clog2(N_TERMS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_acc,
    output logic [Q_W-1:0]    res_q,
    output logic              res_ovf,
    output logic [CNT_W-1:0]  term_cnt,
    output acc_state_e        state_dbg
);

    // Handshakes: a product transfers on a rising edge where prod_valid && prod_ready;
    // a result transfers on a rising edge where res_valid && res_ready. Both ready/valid
    // outputs are registered, so a taken result frees the input one cycle later.

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    acc_state_e       state;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    logic [ACC_W:0]   sum_full;
    logic [ACC_W-1:0] sum_sat;
    logic             sum_ovf;
    logic             accept;
    logic             last_term;
    logic [Q_W-1:0]   q_next;

    // One spare bit catches the carry so the sum clamps instead of wrapping.
    assign sum_full  = {1'b0, acc} + (ACC_W + 1)'(prod);
    assign sum_ovf   = sum_full[ACC_W];
    assign sum_sat   = sum_ovf ? '1 : sum_full[ACC_W-1:0];
    assign accept    = prod_valid && prod_ready;
    assign last_term = (term_cnt == LAST_CNT);
    assign state_dbg = state;

    lenet_requant_u8 #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc (sum_sat),
        .q   (q_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACC;
            acc        <= '0;
            term_cnt   <= '0;
            ovf        <= 1'b0;
            prod_ready <= 1'b0;
            res_valid  <= 1'b0;
            res_acc    <= '0;
            res_q      <= '0;
            res_ovf    <= 1'b0;
        end else if (clr) begin
            state      <= ACC;
            acc        <= '0;
            term_cnt   <= '0;
            ovf        <= 1'b0;
            prod_ready <= 1'b1;
            res_valid  <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    prod_ready <= 1'b1;
                    if (accept) begin
                        if (last_term) begin
                            res_acc    <= sum_sat;
                            res_q      <= q_next;
                            res_ovf    <= ovf | sum_ovf;
                            acc        <= '0;
                            term_cnt   <= '0;
                            ovf        <= 1'b0;
                            res_valid  <= 1'b1;
                            prod_ready <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            acc      <= sum_sat;
                            ovf      <= ovf | sum_ovf;
                            term_cnt <= term_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        prod_ready <= 1'b1;
                        state      <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lenet_xfyw_mac_acc.sv
// Directed and randomized checks of the windowed product accumulator against
// an arithmetic reference model (plain sums, clamp, shift, min).
module tb_lenet_xfyw_mac_acc;

    localparam int     N    = 25;
    localparam int     AW   = 24;
    localparam int     SH   = 8;
    localparam longint AMAX = (longint'(1) << AW) - 1;
    localparam int     N2   = 2;
    localparam int     AW2  = 16;
    localparam longint AMAX2 = (longint'(1) << AW2) - 1;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic prod_valid;
    logic prod_ready;
    logic [15:0] prod;
    logic res_valid;
    logic res_ready;
    logic [AW-1:0] res_acc;
    logic [7:0] res_q;
    logic res_ovf;
    logic [4:0] term_cnt;
    lenet_acc_pkg::acc_state_e st_dbg;

    logic s_clr;
    logic s_prod_valid;
    logic s_prod_ready;
    logic [15:0] s_prod;
    logic s_res_valid;
    logic s_res_ready;
    logic [AW2-1:0] s_res_acc;
    logic [7:0] s_res_q;
    logic s_res_ovf;
    logic [0:0] s_term_cnt;
    lenet_acc_pkg::acc_state_e s_st_dbg;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    longint msum = 0;
    int     mcnt = 0;
    logic [AW-1:0] exp_q[$];
    logic          exp_ovf_q[$];
    longint s_msum = 0;
    int     s_mcnt = 0;
    logic [AW2-1:0] exp_s_q[$];
    logic           exp_s_ovf_q[$];

    lenet_xfyw_mac_acc dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_acc    (res_acc),
        .res_q      (res_q),
        .res_ovf    (res_ovf),
        .term_cnt   (term_cnt),
        .state_dbg  (st_dbg)
    );

    lenet_xfyw_mac_acc #(
        .N_TERMS (N2),
        .ACC_W   (AW2),
        .SHIFT   (SH)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .clr        (s_clr),
        .prod_valid (s_prod_valid),
        .prod_ready (s_prod_ready),
        .prod       (s_prod),
        .res_valid  (s_res_valid),
        .res_ready  (s_res_ready),
        .res_acc    (s_res_acc),
        .res_q      (s_res_q),
        .res_ovf    (s_res_ovf),
        .term_cnt   (s_term_cnt),
        .state_dbg  (s_st_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    function automatic logic [7:0] q_of(input longint a, input int sh);
        longint s;
        s = a >> sh;
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboards: compare every result at the edge where it is taken.
    always @(negedge clk) begin
        logic [AW-1:0] e;
        logic          eo;
        if (!rst && res_valid && res_ready) begin
            check("sb_has_expect", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                eo = exp_ovf_q.pop_front();
                check("sb_res_acc", res_acc, e);
                check("sb_res_q", res_q, q_of(longint'(e), SH));
                check("sb_res_ovf", res_ovf, eo);
            end
        end
    end

    always @(negedge clk) begin
        logic [AW2-1:0] e;
        logic           eo;
        if (!rst && s_res_valid && s_res_ready) begin
            check("sb_s_has_expect", exp_s_q.size() != 0, 1);
            if (exp_s_q.size() != 0) begin
                e  = exp_s_q.pop_front();
                eo = exp_s_ovf_q.pop_front();
                check("sb_s_res_acc", s_res_acc, e);
                check("sb_s_res_q", s_res_q, q_of(longint'(e), SH));
                check("sb_s_res_ovf", s_res_ovf, eo);
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v, output int acc_cyc);
        int n;
        logic [AW-1:0] e;
        n = 0;
        acc_cyc = -1;
        prod = v;
        prod_valid = 1'b1;
        while (!prod_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            check("push_timeout", prod_ready, 1);
        end else begin
            step();
            acc_cyc = cyc;
            msum += v;
            mcnt++;
            if (mcnt == N) begin
                e = (msum > AMAX) ? '1 : AW'(msum);
                exp_q.push_back(e);
                exp_ovf_q.push_back(msum > AMAX);
                msum = 0;
                mcnt = 0;
            end
        end
        prod_valid = 1'b0;
    endtask

    task automatic push_s(input logic [15:0] v);
        int n;
        logic [AW2-1:0] e;
        n = 0;
        s_prod = v;
        s_prod_valid = 1'b1;
        while (!s_prod_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            check("push_s_timeout", s_prod_ready, 1);
        end else begin
            step();
            s_msum += v;
            s_mcnt++;
            if (s_mcnt == N2) begin
                e = (s_msum > AMAX2) ? '1 : AW2'(s_msum);
                exp_s_q.push_back(e);
                exp_s_ovf_q.push_back(s_msum > AMAX2);
                s_msum = 0;
                s_mcnt = 0;
            end
        end
        s_prod_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!res_valid && n < 200) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic take();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("take_prod_ready", prod_ready, 1);
        check("take_res_valid", res_valid, 0);
    endtask

    initial begin
        int c;
        int c1;
        int c2;
        rst = 1'b1;
        clr = 1'b0;
        prod_valid = 1'b0;
        prod = '0;
        res_ready = 1'b0;
        s_clr = 1'b0;
        s_prod_valid = 1'b0;
        s_prod = '0;
        s_res_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_res_valid", res_valid, 0);
        check("rst_res_acc", res_acc, 0);
        check("rst_res_q", res_q, 0);
        check("rst_res_ovf", res_ovf, 0);
        check("rst_term_cnt", term_cnt, 0);
        check("rst_state", st_dbg, lenet_acc_pkg::ACC);
        rst = 1'b0;
        step();
        check("post_rst_prod_ready", prod_ready, 1);

        // 25 back-to-back products of 100
        for (int i = 0; i < N; i++) push(16'd100, c);
        wait_result("t1", 0);
        check("t1_res_acc", res_acc, 2500);
        check("t1_res_q", res_q, 9);
        check("t1_res_ovf", res_ovf, 0);
        check("t1_prod_ready", prod_ready, 0);
        take();

        // Max products with a 10-cycle consumer stall
        for (int i = 0; i < N; i++) push(16'hFFFF, c);
        wait_result("t2", 0);
        for (int i = 0; i < 10; i++) begin
            check("t2_stall_valid", res_valid, 1);
            check("t2_stall_acc", res_acc, 1638375);
            check("t2_stall_q", res_q, 255);
            check("t2_stall_ready", prod_ready, 0);
            step();
        end
        take();

        // Narrow accumulator: saturation then sticky flag clears on next window
        push_s(16'd40000);
        push_s(16'd40000);
        check("t3_valid", s_res_valid, 1);
        check("t3_acc", s_res_acc, 65535);
        check("t3_ovf", s_res_ovf, 1);
        push_s(16'd1);
        push_s(16'd1);
        check("t3b_valid", s_res_valid, 1);
        check("t3b_acc", s_res_acc, 2);
        check("t3b_ovf", s_res_ovf, 0);
        step();

        // Partial window with bubbles, then clr with a product presented
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) step();
            push(16'd7, c);
        end
        check("t4_cnt_before_clr", term_cnt, 12);
        clr = 1'b1;
        prod_valid = 1'b1;
        prod = 16'd7;
        step();
        clr = 1'b0;
        prod_valid = 1'b0;
        msum = 0;
        mcnt = 0;
        check("t4_cnt_after_clr", term_cnt, 0);
        check("t4_valid_after_clr", res_valid, 0);
        for (int i = 0; i < N; i++) push(16'd1, c);
        wait_result("t4", 0);
        check("t4_res_acc", res_acc, 25);
        check("t4_res_q", res_q, 0);
        take();

        // Async reset mid-cycle while holding a result
        for (int i = 0; i < N; i++) push(16'($urandom_range(0, 65535)), c);
        wait_result("t5", 0);
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_valid", res_valid, 0);
        check("t5_async_acc", res_acc, 0);
        check("t5_async_q", res_q, 0);
        check("t5_async_cnt", term_cnt, 0);
        void'(exp_q.pop_back());
        void'(exp_ovf_q.pop_back());
        msum = 0;
        mcnt = 0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) push(16'd256, c);
        wait_result("t5b", 0);
        check("t5b_res_acc", res_acc, 6400);
        check("t5b_res_q", res_q, 25);
        take();

        // Two random windows back-to-back with the consumer always ready
        res_ready = 1'b1;
        c1 = 0;
        for (int i = 0; i < N; i++) push(16'($urandom_range(0, 65535)), c1);
        push(16'($urandom_range(0, 65535)), c2);
        check("t6_restart_gap", c2 - c1, 2);
        for (int i = 1; i < N; i++) push(16'($urandom_range(0, 65535)), c);
        wait_result("t6", 0);
        step();
        res_ready = 1'b0;
        check("t6_valid_after_take", res_valid, 0);
        check("sb_drained", exp_q.size(), 0);
        check("sb_s_drained", exp_s_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
